// File: rtl/control_word_encoder_pkg.sv
// Shared definitions for the control-word encoder: op codes, field bit positions, FSM states.
// The selector imports the same package so the encoder and the decoder use one field layout.
package control_word_encoder_pkg;

   localparam logic [2:0] OP_DEV_EQ_ALU     = 3'd0;
   localparam logic [2:0] OP_DEV_EQ_CONST8  = 3'd1;
   localparam logic [2:0] OP_IMM16_2        = 3'd2;
   localparam logic [2:0] OP_IMM16_4        = 3'd4;
   localparam logic [2:0] OP_IMM16_5        = 3'd5;
   localparam logic [2:0] OP_RAM_ABS_EQ_DEV = 3'd6;

   localparam int OP_LSB       = 21;
   localparam int TARG_LSB     = 16;
   localparam int LBUS_LSB     = 9;
   localparam int RBUS_LSB     = 5;
   localparam int ALUOP_LSB    = 0;
   localparam int IMM_LSB      = 0;
   localparam int RAM_LBUS_LSB = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HI   = 2'd1;
   localparam logic [1:0] ST_MID  = 2'd2;
   localparam logic [1:0] ST_LO   = 2'd3;

   typedef struct packed {
      logic [2:0]  op;
      logic [4:0]  targ;
      logic [3:0]  lbus;
      logic [3:0]  rbus;
      logic [4:0]  aluop;
      logic [15:0] imm;
   } fields_t;

endpackage

// File: rtl/control_word_encoder_pack.sv
// control_word_pack: combinational packing of decoded control fields into a 24-bit ROM word.
// Ops 3 and 7 have no encoding and raise illegal with an all-zero word.
module control_word_pack
   import control_word_encoder_pkg::*;
(
   input  fields_t     fields,
   output logic [23:0] word,
   output logic        illegal
);

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      word[OP_LSB +: 3] = fields.op;
      case (fields.op)
         OP_DEV_EQ_ALU: begin
            word[TARG_LSB  +: 5] = fields.targ;
            word[LBUS_LSB  +: 4] = fields.lbus;
            word[RBUS_LSB  +: 4] = fields.rbus;
            word[ALUOP_LSB +: 5] = fields.aluop;
         end
         OP_DEV_EQ_CONST8: begin
            word[TARG_LSB +: 5] = fields.targ;
            word[IMM_LSB  +: 8] = fields.imm[7:0];
         end
         OP_IMM16_2, OP_IMM16_4, OP_IMM16_5: begin
            word[TARG_LSB +: 5]  = fields.targ;
            word[IMM_LSB  +: 16] = fields.imm;
         end
         OP_RAM_ABS_EQ_DEV: begin
            word[RAM_LBUS_LSB +: 4] = fields.lbus;
            word[IMM_LSB      +: 16] = fields.imm;
         end
         default: begin
            word    = '0;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/control_word_encoder.sv
// control_word_encoder: packs control fields into a 24-bit word and streams it as hi/mid/lo bytes.
// Optional running XOR checksum of emitted bytes when CONTROL_WORD_ENCODER_CHECKSUM_EN is defined.
module control_word_encoder
   import control_word_encoder_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter bit LOG    = 1'b0
) (
   input  logic              clk,
   input  logic              MR,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        op,
   input  logic [4:0]        targ,
   input  logic [3:0]        lbus,
   input  logic [3:0]        rbus,
   input  logic [4:0]        aluop,
   input  logic [15:0]       imm,
   input  logic              addr_load,
   input  logic [ADDR_W-1:0] addr_in,
   output logic [7:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err,
   output logic [7:0]        checksum
);

   logic [1:0]  state;
   logic [23:0] word_q;
   logic [23:0] packed_word;
   logic        illegal;
   logic        accept;
   logic        xfer;
   logic        load_now;
   fields_t     fields;

   assign fields = {op, targ, lbus, rbus, aluop, imm};

   control_word_pack u_pack (
      .fields  (fields),
      .word    (packed_word),
      .illegal (illegal)
   );

   assign in_ready  = (state == ST_IDLE) && !MR;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state != ST_IDLE);
   assign xfer      = out_valid && out_ready;
   assign load_now  = addr_load && (state == ST_IDLE);

   always_ff @(posedge clk or posedge MR) begin
      if (MR) begin
         state <= ST_IDLE;
         err   <= 1'b0;
      end else begin
         err <= accept && illegal;
         case (state)
            ST_IDLE: if (accept && !illegal) state <= ST_HI;
            ST_HI:   if (xfer) state <= ST_MID;
            ST_MID:  if (xfer) state <= ST_LO;
            default: if (xfer) state <= ST_IDLE;
         endcase
      end
   end

   // Word register needs no reset: out_data is forced to zero whenever the FSM is idle.
   always_ff @(posedge clk) begin
      if (accept && !illegal) word_q <= packed_word;
   end

   always_comb begin
      out_data = 8'h00;
      case (state)
         ST_HI:   out_data = word_q[23:16];
         ST_MID:  out_data = word_q[15:8];
         ST_LO:   out_data = word_q[7:0];
         default: out_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge MR) begin
      if (MR)            out_addr <= '0;
      else if (load_now) out_addr <= addr_in;
      else if (xfer)     out_addr <= out_addr + ADDR_W'(1);
   end

`ifdef CONTROL_WORD_ENCODER_CHECKSUM_EN
   logic [7:0] checksum_q;

   always_ff @(posedge clk or posedge MR) begin
      if (MR)            checksum_q <= 8'h00;
      else if (load_now) checksum_q <= 8'h00;
      else if (xfer)     checksum_q <= checksum_q ^ out_data;
   end

   assign checksum = checksum_q;
`else
   assign checksum = 8'h00;
`endif

   // Transaction logging belongs to simulation wrappers; the synthesizable core emits nothing.
   if (LOG) begin : g_log
   end

endmodule

// File: tb/tb_control_word_encoder.sv
// Scoreboard bench for control_word_encoder: directed field/backpressure/wrap/reset cases plus random words.
module tb_control_word_encoder;

   logic        clk = 1'b0;
   logic        MR = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  op = '0;
   logic [4:0]  targ = '0;
   logic [3:0]  lbus = '0;
   logic [3:0]  rbus = '0;
   logic [4:0]  aluop = '0;
   logic [15:0] imm = '0;
   logic        addr_load = 1'b0;
   logic [15:0] addr_in = '0;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_addr;
   logic        err;
   logic [7:0]  checksum;

   logic force_on = 1'b1;
   logic force_val = 1'b1;
   logic rnd_ready = 1'b1;
   assign out_ready = force_on ? force_val : rnd_ready;

   typedef struct {
      logic [7:0]  data;
      logic [15:0] addr;
      bit          clr;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] model_addr = '0;
   bit          ck_clr_pending = 1'b1;
   logic [7:0]  exp_ck = '0;
   int          passed = 0;
   int          total = 0;

   control_word_encoder #(.ADDR_W(16), .LOG(1'b0)) dut (
      .clk(clk), .MR(MR), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .targ(targ), .lbus(lbus), .rbus(rbus), .aluop(aluop), .imm(imm),
      .addr_load(addr_load), .addr_in(addr_in),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_addr(out_addr), .err(err), .checksum(checksum)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Reference word from the field layout, built with plain arithmetic.
   function automatic logic [23:0] model_word(int o, int t, int l, int r, int a, int i);
      int w;
      case (o)
         0:       w = o * (1 << 21) + t * (1 << 16) + l * (1 << 9) + r * (1 << 5) + a;
         1:       w = o * (1 << 21) + t * (1 << 16) + (i % 256);
         2, 4, 5: w = o * (1 << 21) + t * (1 << 16) + i;
         6:       w = o * (1 << 21) + l * (1 << 16) + i;
         default: w = 0;
      endcase
      return 24'(w);
   endfunction

   // Monitor: pops and compares on every byte handshake.
   always @(negedge clk) begin
      exp_t e;
      if (!MR && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_byte: got data %h at addr %h, expected no byte", out_data, out_addr);
         end else begin
            e = exp_q.pop_front();
            if (e.clr) exp_ck = 8'h00;
            chk("byte_data", 32'(out_data), 32'(e.data));
            chk("byte_addr", 32'(out_addr), 32'(e.addr));
`ifdef CONTROL_WORD_ENCODER_CHECKSUM_EN
            chk("checksum", 32'(checksum), 32'(exp_ck));
`else
            chk("checksum_tied", 32'(checksum), 0);
`endif
            exp_ck = exp_ck ^ e.data;
         end
      end
   end

   task automatic send(input int o, input int t, input int l, input int r, input int a,
                       input int i, input bit ld, input int ld_addr);
      int n = 0;
      logic [23:0] w;
      bit legal;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (!in_ready) begin
         total++;
         $display("FAIL in_ready_timeout: got in_ready 0, expected 1 within 100 cycles");
         return;
      end
      op = 3'(o); targ = 5'(t); lbus = 4'(l); rbus = 4'(r); aluop = 5'(a); imm = 16'(i);
      addr_load = ld; addr_in = 16'(ld_addr); in_valid = 1'b1;
      if (ld) begin
         model_addr = 16'(ld_addr);
         ck_clr_pending = 1'b1;
      end
      legal = !(o == 3 || o == 7);
      if (legal) begin
         w = model_word(o, t, l, r, a, i);
         for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.data = w[23 - 8*k -: 8];
            e.addr = model_addr;
            e.clr  = (k == 0) && ck_clr_pending;
            exp_q.push_back(e);
            model_addr = model_addr + 16'd1;
         end
         ck_clr_pending = 1'b0;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; addr_load = 1'b0;
      chk("err_on_accept", 32'(err), 32'(!legal));
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 300) begin
         @(posedge clk); #1; n++;
      end
      chk("drain_queue_empty", 32'(exp_q.size()), 0);
   endtask

   initial begin
      logic [15:0] addr_before;
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_addr", 32'(out_addr), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_checksum", 32'(checksum), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
      MR = 1'b0;
      @(posedge clk); #1;

      // Field encode: op0 -> 03,05,31 at 0,1,2; in_ready low while emitting.
      force_on = 1'b1; force_val = 1'b1;
      send(0, 3, 2, 9, 'h11, 0, 1'b1, 0);
      for (int k = 0; k < 3; k++) begin
         chk("in_ready_busy", 32'(in_ready), 0);
         @(posedge clk); #1;
      end
      chk("in_ready_idle", 32'(in_ready), 1);
`ifdef CONTROL_WORD_ENCODER_CHECKSUM_EN
      chk("checksum_first_word", 32'(checksum), 32'h37);
`else
      chk("checksum_first_word", 32'(checksum), 0);
`endif

      // Immediate forms.
      send(2, 'h10, 0, 0, 0, 'hBEEF, 1'b0, 0);
      send(6, 0, 'hA, 0, 0, 'h1234, 1'b0, 0);
      send(1, 5, 0, 0, 0, 'h0077, 1'b0, 0);
      drain();

      // Illegal ops: handshake completes, err pulses once, nothing emitted.
      for (int k = 0; k < 2; k++) begin
         addr_before = model_addr;
         send((k == 0) ? 3 : 7, 'h1F, 'hF, 'hF, 'h1F, 'hFFFF, 1'b0, 0);
         chk("illegal_no_valid", 32'(out_valid), 0);
         @(posedge clk); #1;
         chk("illegal_err_drop", 32'(err), 0);
         chk("illegal_no_valid2", 32'(out_valid), 0);
         chk("illegal_addr_kept", 32'(out_addr), 32'(addr_before));
      end
      send(4, 7, 0, 0, 0, 'h5A5A, 1'b0, 0);
      drain();

      // Backpressure during MID for 4 cycles.
      force_val = 1'b0;
      send(2, 'h10, 0, 0, 0, 'hBEEF, 1'b1, 'h0100);
      force_val = 1'b1;
      @(posedge clk); #1;
      force_val = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_data", 32'(out_data), 32'hBE);
         chk("bp_addr", 32'(out_addr), 32'h0101);
      end
      @(posedge clk); #1;
      force_val = 1'b1;
      drain();

      // Load with accept in the same cycle, wrap, and a load during HI that must be ignored.
      send(0, 1, 2, 3, 4, 0, 1'b1, 'hFFFE);
      chk("load_hi_state", 32'(out_addr), 32'hFFFE);
      addr_load = 1'b1; addr_in = 16'h1234;
      @(posedge clk); #1;
      addr_load = 1'b0;
      drain();
      chk("wrap_addr_after", 32'(out_addr), 32'h0001);

      // Reset in MID aborts the word; next word restarts at address 0.
      force_val = 1'b0;
      send(2, 1, 0, 0, 0, 'hAAAA, 1'b1, 'h0200);
      force_val = 1'b1;
      @(posedge clk); #1;
      force_val = 1'b0;
      @(negedge clk);
      MR = 1'b1;
      #1;
      chk("mr_valid_drop", 32'(out_valid), 0);
      chk("mr_addr_zero", 32'(out_addr), 0);
      chk("mr_in_ready", 32'(in_ready), 0);
      chk("mr_checksum", 32'(checksum), 0);
      exp_q.delete();
      model_addr = '0;
      ck_clr_pending = 1'b1;
      force_val = 1'b1;
      @(posedge clk); #1;
      MR = 1'b0;
      send(5, 9, 0, 0, 0, 'hC3C3, 1'b0, 0);
      drain();

      // Random words with random backpressure and occasional loads.
      force_on = 1'b0;
      for (int k = 0; k < 60; k++) begin
         send(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 31)), int'($urandom_range(0, 65535)),
              ($urandom_range(0, 7) == 0), int'($urandom_range(0, 65535)));
      end
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no completion, expected finish before 200000");
      $fatal(1);
   end

endmodule
